// File: rtl/pipelined_monitor_pkg.sv
// Shared constants for the pipelined result monitor: reference-operation
// encodings and default operand/counter widths.
package pipelined_monitor_pkg;

  localparam int OP_ADD    = 0;
  localparam int OP_SUB    = 1;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipelined_monitor_mon_lane.sv
// One check lane: holds a captured DUT transaction, ages it for MON_LATENCY
// cycles while the reference result moves through its pipeline, then flags done.
module mon_lane
  import pipelined_monitor_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int MON_LATENCY = 1,
  parameter int OP          = OP_ADD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] os,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cap_a,
  output logic [WIDTH-1:0] cap_b,
  output logic [WIDTH-1:0] cap_os,
  output logic [WIDTH-1:0] ref_res
);

  localparam int AGE_W = $clog2(MON_LATENCY + 2);

  logic             busy_r;
  logic [AGE_W-1:0] age_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] os_r;
  logic [WIDTH-1:0] pipe_r [MON_LATENCY];
  logic [WIDTH-1:0] ref_s;

  // Reference operation on the incoming operands (modulo 2^WIDTH).
  always_comb begin
    if (OP == OP_SUB) begin
      ref_s = a - b;
    end else begin
      ref_s = a + b;
    end
  end

  // Busy flag and age: set on load, released once the result has aged MON_LATENCY cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      age_r  <= {AGE_W{1'b0}};
    end else if (load) begin
      busy_r <= 1'b1;
      age_r  <= AGE_W'(1);
    end else if (busy_r && (age_r == AGE_W'(MON_LATENCY))) begin
      busy_r <= 1'b0;
      age_r  <= {AGE_W{1'b0}};
    end else if (busy_r) begin
      age_r  <= age_r + AGE_W'(1);
    end else begin
      age_r  <= age_r;
    end
  end

  // Operand capture and reference pipeline; stage 0 loads, later stages free-run.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r  <= {WIDTH{1'b0}};
      b_r  <= {WIDTH{1'b0}};
      os_r <= {WIDTH{1'b0}};
      for (int k = 0; k < MON_LATENCY; k++) begin
        pipe_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      if (load) begin
        a_r       <= a;
        b_r       <= b;
        os_r      <= os;
        pipe_r[0] <= ref_s;
      end
      for (int k = 1; k < MON_LATENCY; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  assign busy    = busy_r;
  assign done    = busy_r && (age_r == AGE_W'(MON_LATENCY));
  assign cap_a   = a_r;
  assign cap_b   = b_r;
  assign cap_os  = os_r;
  assign ref_res = pipe_r[MON_LATENCY-1];

endmodule

// File: rtl/pipelined_monitor.sv
// Pipelined result monitor: distributes DUT transactions round-robin over
// check lanes and reports mismatches, counts and the first failing transaction.
module pipelined_monitor
  import pipelined_monitor_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int NUM_SUB_MON = 2,
  parameter int MON_LATENCY = 1,
  parameter int OP          = OP_ADD,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_dut_ia,
  input  logic [WIDTH-1:0] i_dut_ib,
  input  logic [WIDTH-1:0] i_dut_os,
  output logic             o_ready,
  input  logic             i_clear,
  output logic             o_chk_valid,
  output logic             o_event,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_chk_count,
  output logic             o_first_valid,
  output logic [WIDTH-1:0] o_first_a,
  output logic [WIDTH-1:0] o_first_b,
  output logic [WIDTH-1:0] o_first_dut,
  output logic [WIDTH-1:0] o_first_mon,
  output logic             o_halted
);

  logic [NUM_SUB_MON-1:0] ptr_r;
  logic [NUM_SUB_MON-1:0] busy_s;
  logic [NUM_SUB_MON-1:0] done_s;
  logic [NUM_SUB_MON-1:0] load_s;
  logic [WIDTH-1:0]       lane_a_s   [NUM_SUB_MON];
  logic [WIDTH-1:0]       lane_b_s   [NUM_SUB_MON];
  logic [WIDTH-1:0]       lane_os_s  [NUM_SUB_MON];
  logic [WIDTH-1:0]       lane_ref_s [NUM_SUB_MON];
  logic                   accept_s;
  logic                   sel_done_s;
  logic [WIDTH-1:0]       sel_a_s;
  logic [WIDTH-1:0]       sel_b_s;
  logic [WIDTH-1:0]       sel_os_s;
  logic [WIDTH-1:0]       sel_ref_s;
  logic [WIDTH-1:0]       chk_a_r;
  logic [WIDTH-1:0]       chk_b_r;
  logic [WIDTH-1:0]       chk_os_r;
  logic [WIDTH-1:0]       chk_mon_r;
  logic                   capture_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  assign o_ready   = ~reset & ~o_halted & ~(|(busy_s & ptr_r));
  assign accept_s  = i_valid & o_ready;
  assign load_s    = ptr_r & {NUM_SUB_MON{accept_s}};
  assign capture_s = o_event & (~o_first_valid | i_clear);

  for (genvar g = 0; g < NUM_SUB_MON; g++) begin : g_lane
    mon_lane #(
      .WIDTH      (WIDTH),
      .MON_LATENCY(MON_LATENCY),
      .OP         (OP)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (load_s[g]),
      .a      (i_dut_ia),
      .b      (i_dut_ib),
      .os     (i_dut_os),
      .busy   (busy_s[g]),
      .done   (done_s[g]),
      .cap_a  (lane_a_s[g]),
      .cap_b  (lane_b_s[g]),
      .cap_os (lane_os_s[g]),
      .ref_res(lane_ref_s[g])
    );
  end

  // One-hot lane pointer, advancing only on an accepted transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= {{(NUM_SUB_MON-1){1'b0}}, 1'b1};
    end else if (accept_s) begin
      ptr_r <= {ptr_r[NUM_SUB_MON-2:0], ptr_r[NUM_SUB_MON-1]};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // At most one lane completes per cycle, so an AND-OR mux is sufficient.
  always_comb begin
    sel_done_s = 1'b0;
    sel_a_s    = {WIDTH{1'b0}};
    sel_b_s    = {WIDTH{1'b0}};
    sel_os_s   = {WIDTH{1'b0}};
    sel_ref_s  = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_SUB_MON; i++) begin
      sel_done_s = sel_done_s | done_s[i];
      sel_a_s    = sel_a_s   | ({WIDTH{done_s[i]}} & lane_a_s[i]);
      sel_b_s    = sel_b_s   | ({WIDTH{done_s[i]}} & lane_b_s[i]);
      sel_os_s   = sel_os_s  | ({WIDTH{done_s[i]}} & lane_os_s[i]);
      sel_ref_s  = sel_ref_s | ({WIDTH{done_s[i]}} & lane_ref_s[i]);
    end
  end

  // Registered check result stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_chk_valid <= 1'b0;
      o_event     <= 1'b0;
      chk_a_r     <= {WIDTH{1'b0}};
      chk_b_r     <= {WIDTH{1'b0}};
      chk_os_r    <= {WIDTH{1'b0}};
      chk_mon_r   <= {WIDTH{1'b0}};
    end else begin
      o_chk_valid <= sel_done_s;
      o_event     <= sel_done_s & (sel_os_s != sel_ref_s);
      chk_a_r     <= sel_a_s;
      chk_b_r     <= sel_b_s;
      chk_os_r    <= sel_os_s;
      chk_mon_r   <= sel_ref_s;
    end
  end

  // Counters, halt and first-mismatch capture; a check completing with i_clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_chk_count   <= {CNT_W{1'b0}};
      o_err_count   <= {CNT_W{1'b0}};
      o_halted      <= 1'b0;
      o_first_valid <= 1'b0;
      o_first_a     <= {WIDTH{1'b0}};
      o_first_b     <= {WIDTH{1'b0}};
      o_first_dut   <= {WIDTH{1'b0}};
      o_first_mon   <= {WIDTH{1'b0}};
    end else begin
      o_chk_count   <= sat_inc(i_clear ? {CNT_W{1'b0}} : o_chk_count, o_chk_valid);
      o_err_count   <= sat_inc(i_clear ? {CNT_W{1'b0}} : o_err_count, o_event);
      o_halted      <= (o_halted & ~i_clear) | ((STOP_ON_ERR != 0) & o_event);
      o_first_valid <= (o_first_valid & ~i_clear) | o_event;
      if (capture_s) begin
        o_first_a   <= chk_a_r;
        o_first_b   <= chk_b_r;
        o_first_dut <= chk_os_r;
        o_first_mon <= chk_mon_r;
      end else begin
        o_first_a   <= o_first_a;
        o_first_b   <= o_first_b;
        o_first_dut <= o_first_dut;
        o_first_mon <= o_first_mon;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_monitor.sv
// Scoreboard bench for pipelined_monitor: two configurations (add, full rate;
// subtract, stalling, stop-on-error) driven together against a timestamp model.
module tb_pipelined_monitor;

  localparam int W  = 16;
  localparam int CW = 4;
  localparam int NL = 2;

  typedef struct {
    int         inst;
    int         due;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] os;
    logic [W-1:0] mon;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset, valid, clear;
  logic [W-1:0]  ia, ib;
  logic [W-1:0]  os [2];
  logic          ready [2], chk_valid [2], evt [2], first_valid [2], halted [2];
  logic [CW-1:0] err_cnt [2], chk_cnt [2];
  logic [W-1:0]  fa [2], fb [2], fdut [2], fmon [2];

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   armed = 1'b0;
  ent_t q [$];

  int            last_m [2][NL];
  int            ptr_m [2];
  bit            halt_m [2], fv_m [2];
  logic [CW-1:0] chk_m [2], err_m [2];
  logic [W-1:0]  fa_m [2], fb_m [2], fdut_m [2], fmon_m [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_monitor #(.WIDTH(W), .NUM_SUB_MON(NL), .MON_LATENCY(1), .OP(0),
                      .CNT_W(CW), .STOP_ON_ERR(0)) dut_a (
    .clk(clk), .reset(reset), .i_valid(valid), .i_dut_ia(ia), .i_dut_ib(ib),
    .i_dut_os(os[0]), .o_ready(ready[0]), .i_clear(clear),
    .o_chk_valid(chk_valid[0]), .o_event(evt[0]), .o_err_count(err_cnt[0]),
    .o_chk_count(chk_cnt[0]), .o_first_valid(first_valid[0]), .o_first_a(fa[0]),
    .o_first_b(fb[0]), .o_first_dut(fdut[0]), .o_first_mon(fmon[0]),
    .o_halted(halted[0]));

  pipelined_monitor #(.WIDTH(W), .NUM_SUB_MON(NL), .MON_LATENCY(3), .OP(1),
                      .CNT_W(CW), .STOP_ON_ERR(1)) dut_b (
    .clk(clk), .reset(reset), .i_valid(valid), .i_dut_ia(ia), .i_dut_ib(ib),
    .i_dut_os(os[1]), .o_ready(ready[1]), .i_clear(clear),
    .o_chk_valid(chk_valid[1]), .o_event(evt[1]), .o_err_count(err_cnt[1]),
    .o_chk_count(chk_cnt[1]), .o_first_valid(first_valid[1]), .o_first_a(fa[1]),
    .o_first_b(fb[1]), .o_first_dut(fdut[1]), .o_first_mon(fmon[1]),
    .o_halted(halted[1]));

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [W-1:0] ref_op(int i, logic [W-1:0] a, logic [W-1:0] b);
    int unsigned r;
    r = (i == 0) ? (int'(a) + int'(b)) : (int'(a) + 65536 - int'(b));
    return W'(r % 65536);
  endfunction

  function automatic logic [CW-1:0] sat(logic [CW-1:0] v);
    int n;
    n = int'(v) + 1;
    return CW'((n > 15) ? 15 : n);
  endfunction

  task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst %0d cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  // Monitor and reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int k;
      bit exp_v, mis, exp_rdy;
      k = -1;
      for (int j = 0; j < q.size(); j++) begin
        if (k < 0 && q[j].inst == i) k = j;
      end
      exp_v   = (k >= 0) && (q[k].due == cyc);
      mis     = exp_v && (q[k].os != q[k].mon);
      exp_rdy = !reset && !halt_m[i] && (cyc - last_m[i][ptr_m[i]] > lat(i));
      if (armed) begin
        check("o_ready", i, 32'(ready[i]), 32'(exp_rdy));
        check("o_chk_valid", i, 32'(chk_valid[i]), 32'(exp_v));
        if (exp_v) check("o_event", i, 32'(evt[i]), 32'(mis));
        else check("o_event_idle", i, 32'(evt[i]), 32'(0));
        check("o_chk_count", i, 32'(chk_cnt[i]), 32'(chk_m[i]));
        check("o_err_count", i, 32'(err_cnt[i]), 32'(err_m[i]));
        check("o_first_valid", i, 32'(first_valid[i]), 32'(fv_m[i]));
        check("o_first_a", i, 32'(fa[i]), 32'(fa_m[i]));
        check("o_first_b", i, 32'(fb[i]), 32'(fb_m[i]));
        check("o_first_dut", i, 32'(fdut[i]), 32'(fdut_m[i]));
        check("o_first_mon", i, 32'(fmon[i]), 32'(fmon_m[i]));
        check("o_halted", i, 32'(halted[i]), 32'(halt_m[i]));
      end
      if (clear) begin
        chk_m[i] = '0; err_m[i] = '0; fv_m[i] = 1'b0; halt_m[i] = 1'b0;
      end
      if (exp_v) begin
        chk_m[i] = sat(chk_m[i]);
        if (mis) begin
          err_m[i] = sat(err_m[i]);
          if (i == 1) halt_m[i] = 1'b1;
          if (!fv_m[i]) begin
            fv_m[i] = 1'b1;
            fa_m[i] = q[k].a; fb_m[i] = q[k].b; fdut_m[i] = q[k].os; fmon_m[i] = q[k].mon;
          end
        end
        q.delete(k);
      end
      if (valid && exp_rdy) begin
        q.push_back('{inst: i, due: cyc + lat(i) + 1, a: ia, b: ib, os: os[i],
                      mon: ref_op(i, ia, ib)});
        last_m[i][ptr_m[i]] = cyc;
        ptr_m[i] = (ptr_m[i] + 1) % NL;
      end
    end
    if (reset) begin
      q.delete();
      for (int i = 0; i < 2; i++) begin
        ptr_m[i] = 0; halt_m[i] = 1'b0; fv_m[i] = 1'b0;
        chk_m[i] = '0; err_m[i] = '0;
        fa_m[i] = '0; fb_m[i] = '0; fdut_m[i] = '0; fmon_m[i] = '0;
        for (int j = 0; j < NL; j++) last_m[i][j] = -100;
      end
      armed = 1'b1;
    end
  end

  task automatic drive(bit rst, bit v, logic [W-1:0] a, logic [W-1:0] b, bit bad, bit clr);
    @(posedge clk);
    #1;
    reset = rst; valid = v; ia = a; ib = b; clear = clr;
    for (int i = 0; i < 2; i++) os[i] = ref_op(i, a, b) + (bad ? 16'd1 : 16'd0);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; clear = 1'b0; ia = '0; ib = '0;
    os[0] = '0; os[1] = '0;
    repeat (3) drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) drive(1'b0, 1'b1, W'(k), W'(k + 1), 1'b0, 1'b0);
    repeat (6) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'd5, 16'd7, 1'b1, 1'b0);
    repeat (8) drive(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (300) drive(1'b0, $urandom_range(0, 9) < 7, W'($urandom), W'($urandom),
                       $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
    repeat (6) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (25) drive(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
    repeat (6) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    repeat (6) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
    repeat (2) drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_monitor.md
PIPELINED_MONITOR -- requirements
Module: pipelined_monitor

Interface
REQ-001 Parameters (name, default, meaning): WIDTH, 32, operand/result width.
REQ-002 NUM_SUB_MON, 2, number of round-robin check lanes (>=2).
REQ-003 MON_LATENCY, 1, reference-model pipeline depth in cycles (>=1).
REQ-004 OP, 0, reference operation: 0 = a+b, 1 = a-b, both mod 2^WIDTH.
REQ-005 CNT_W, 16, error/check counter width.
REQ-006 STOP_ON_ERR, 0, 1 = halt acceptance after first mismatch.
REQ-007 Ports: clk  in  1  sole clock, all logic on posedge; reset  in  1  synchronous, active-high.
REQ-008 i_valid  in  1  DUT transaction present; i_dut_ia, i_dut_ib, i_dut_os  in  WIDTH each  DUT operands and result.
REQ-009 o_ready  out  1  transaction accepted this cycle when i_valid & o_ready.
REQ-010 i_clear  in  1  clears counters, capture and halt.
REQ-011 o_chk_valid  out  1  one-cycle pulse per completed check; o_event  out  1  mismatch pulse, only with o_chk_valid.
REQ-012 o_err_count, o_chk_count  out  CNT_W  saturating mismatch and check counts.
REQ-013 o_first_valid  out  1; o_first_a, o_first_b, o_first_dut, o_first_mon  out  WIDTH each  first-mismatch capture.
REQ-014 o_halted  out  1  acceptance stopped by STOP_ON_ERR.

Function
REQ-015 Distributor: one-hot lane pointer, lane 0 after reset, advances by one lane (wrapping NUM_SUB_MON-1 -> 0) only on an accepted transaction.
REQ-016 Accepted transaction captured into the pointed lane together with a lane busy flag, same edge.
REQ-017 Lane busy for MON_LATENCY+1 cycles after acceptance; o_ready = !busy[pointer] & !o_halted & !reset-state.
REQ-018 With NUM_SUB_MON >= MON_LATENCY+1, o_ready stays high under continuous i_valid (one check per cycle); otherwise o_ready drops while the pointed lane is busy, no transaction lost.
REQ-019 Latency: transaction accepted at cycle N produces o_chk_valid at cycle N+MON_LATENCY+1; results leave in acceptance order, at most one per cycle.
REQ-020 o_event = o_chk_valid & (captured i_dut_os != reference result); no event without o_chk_valid.
REQ-021 o_chk_count increments per o_chk_valid, o_err_count per o_event; both hold at 2^CNT_W-1.
REQ-022 First mismatch while o_first_valid=0 loads o_first_* and sets o_first_valid; later mismatches do not overwrite.
REQ-023 STOP_ON_ERR=1: o_halted sets the cycle after the first o_event; checks already in flight still complete and count.
REQ-024 i_clear: next cycle counters 0, o_first_valid 0, o_halted 0; in-flight lanes unaffected; a mismatch completing in the i_clear cycle wins and yields count 1 and a fresh capture.
REQ-025 i_valid while o_ready=0: ignored; pointer holds.

Reset
REQ-026 On reset: pointer lane 0, all busy flags 0, o_ready 0, o_chk_valid 0, o_event 0, counters 0, o_first_* 0, o_first_valid 0, o_halted 0.
REQ-027 o_ready rises the first cycle after reset deasserts; reset mid-operation discards all in-flight checks with no o_chk_valid pulse.

Structure
REQ-028 Shared package holds OP encodings (OP_ADD=0, OP_SUB=1) and the default WIDTH/CNT_W constants.
REQ-029 One sub-module, mon_lane: per-lane capture registers, busy/age counter and MON_LATENCY-stage reference pipeline; instantiated NUM_SUB_MON times; top holds pointer, output mux, counters, capture.
REQ-030 No derived or gated clocks; lane enables only.

Verification
REQ-031 Defaults, 4 back-to-back correct adds (1+2=3, ...) -> o_ready constant 1, four o_chk_valid pulses at N+2..N+5, o_err_count 0, o_chk_count 4.
REQ-032 Single bad result a=5, b=7, os=13 -> one o_event, o_err_count 1, o_first_a=5, o_first_b=7, o_first_dut=13, o_first_mon=12.
REQ-033 NUM_SUB_MON=2, MON_LATENCY=3, continuous i_valid -> o_ready 50% duty, every accepted transaction checked, in order.
REQ-034 STOP_ON_ERR=1, mismatch then continued i_valid -> o_halted 1, o_ready 0 until i_clear, then counters 0 and acceptance resumes.
REQ-035 CNT_W=4, 20 mismatches -> o_err_count saturates at 15; o_first_* equals first mismatch.
REQ-036 reset asserted with 2 checks in flight -> no o_chk_valid afterwards, all outputs at reset values, o_ready 1 the cycle after release.
